reqack_arbiter_n2one: RTL
=========================

Name: reqack_arbiter_n2one

Overview:
- Parametrised N-producer to 1-consumer arbiter; all ports use the four-phase request/acknowledge protocol.
- Acts as a single pipeline stage: latches the granted producer's data and re-issues it on the consumer port.
- Selectable round-robin or fixed-priority policy.
- Configurable synchroniser depth, so producers and consumer may sit in other clock domains.

Parameters:
- NPROD, 4, number of producer ports; legal range 2..32.
- DWIDTH, 8, data bits per port.
- SYNC_STAGES, 2, flop stages on each prod_req bit and on cons_ack; 0 = no synchroniser, inputs used directly.
- PRIO_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous, active-low.
- prod_req  input  NPROD  per-producer request.
- prod_ack  output  NPROD  per-producer acknowledge.
- prod_dat  input  NPROD*DWIDTH  producer i data in bits [i*DWIDTH +: DWIDTH]; must be stable while prod_req[i] is high.
- cons_req  output  1  consumer request.
- cons_ack  input  1  consumer acknowledge.
- cons_dat  output  DWIDTH  data of the last granted producer.
- grant_idx  output  IW  index of the last granted producer; IW = max(1, $clog2(NPROD)).
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset: all outputs go to 0 asynchronously. FSM enters IDLE, synchronisers clear, and the round-robin pointer is set to NPROD-1, so index 0 has first priority.
- Reset mid-transaction: the transaction is abandoned silently. No ack is completed; a producer still holding req is re-arbitrated after reset.
- Synchronised signals: sreq[i] and sack are the synchronised prod_req[i] and cons_ack.
- Only one consumer transaction is ever outstanding.
- FSM states: IDLE, CREQ, CACK, PDONE.
- IDLE: if any sreq is high, select g.
  - Round-robin: first set index scanning last+1, last+2, ... with wrap-around modulo NPROD.
  - Fixed priority: lowest set index.
  - On the next edge: cons_req=1, prod_ack[g]=1, cons_dat=prod_dat[g], grant_idx=g, last=g (round-robin only), go to CREQ.
- CREQ: on sack=1, set cons_req=0 and go to CACK.
- CACK: on sack=0, go to PDONE.
- PDONE: while sreq[g]=1, hold prod_ack[g]=1. On sreq[g]=0, set prod_ack[g]=0 and go to IDLE.
- The producer ack therefore stays high until both the consumer handshake and the producer request fall have completed.
- Latency, from prod_req rising (setup-valid before an edge) to prod_ack/cons_req rising: SYNC_STAGES+1 clk edges; 1 edge when SYNC_STAGES=0.
- Minimum gap: at least one IDLE cycle separates consecutive grants.
- Losing producers: prod_ack stays low; they remain pending with no starvation under round-robin (each waits at most NPROD-1 grants).
- Producer withdraws req before grant (protocol violation): it is simply not granted; no ack pulse.
- Simultaneous requests in the same cycle are resolved purely by policy; the pointer updates only on a grant.
- cons_dat and grant_idx are held stable from a grant until the next grant.
- At most one prod_ack bit is high at any time; a bench assertion checks this onehot0 property.
- Pointer wrap: after granting index NPROD-1, the round-robin scan starts at 0.

Test Plan:
- Single producer, NPROD=4, SYNC_STAGES=2: prod_req[2]=1 with dat=0xA5 -> after 3 edges prod_ack=4'b0100, cons_req=1, cons_dat=0xA5, grant_idx=2. Consumer acks and releases; prod_req drops -> prod_ack returns to 0 and busy=0.
- Round-robin fairness: all four reqs held high and re-raised after each ack fall -> grant order 0,1,2,3,0,1 with cons_dat matching each producer's data.
- Fixed priority (PRIO_MODE=1): reqs 1 and 3 constantly pending -> index 1 granted every transaction; index 3 only when req1 is low.
- Late consumer release: producer drops req while cons_ack is still high -> prod_ack stays 1 until cons_ack falls, then clears. Late producer release: prod_ack stays 1 in PDONE until req falls.
- SYNC_STAGES=0, NPROD=2: req0 and req1 rise in the same cycle from reset -> grant 0 after 1 edge, then grant 1 on the next transaction.
- Async reset asserted in CREQ -> cons_req, prod_ack, busy, cons_dat and grant_idx are 0 immediately. After release, a still-high req is granted again with latency SYNC_STAGES+1.

Source files
------------

// File: rtl/reqack_arbiter_n2one.sv
// ----------------------------------------------------------------------------
// reqack_arbiter_n2one
//
// N-producer to 1-consumer arbiter built as a single pipeline stage. Every
// port speaks four-phase request/acknowledge. The winning producer's data is
// latched and re-issued to the consumer; the producer acknowledge is held
// until both the consumer handshake and the producer's request release have
// completed. Policy is round-robin or fixed priority (lowest index wins).
// prod_req and cons_ack pass through a configurable synchroniser so the
// producers and the consumer may live in other clock domains.
//
// Parameters:
//   NPROD        number of producer ports (2..32)
//   DWIDTH       data bits per port
//   SYNC_STAGES  flops on each prod_req bit and on cons_ack (0 = none)
//   PRIO_MODE    0 = round-robin, 1 = fixed priority
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   prod_req   per-producer request
//   prod_ack   per-producer acknowledge (at most one bit high)
//   prod_dat   producer i data in bits [i*DWIDTH +: DWIDTH]
//   cons_req   consumer request
//   cons_ack   consumer acknowledge
//   cons_dat   data of the last granted producer
//   grant_idx  index of the last granted producer
//   busy       high whenever the FSM is not idle
// ----------------------------------------------------------------------------
module reqack_arbiter_n2one #(
    parameter int unsigned NPROD       = 4,
    parameter int unsigned DWIDTH      = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned PRIO_MODE   = 0,
    localparam int unsigned IW         = (NPROD > 1) ? $clog2(NPROD) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NPROD-1:0]        prod_req,
    output logic [NPROD-1:0]        prod_ack,
    input  logic [NPROD*DWIDTH-1:0] prod_dat,
    output logic                    cons_req,
    input  logic                    cons_ack,
    output logic [DWIDTH-1:0]       cons_dat,
    output logic [IW-1:0]           grant_idx,
    output logic                    busy
);

    localparam int NP = int'(NPROD);

    typedef enum logic [1:0] {
        StIdle,
        StCreq,
        StCack,
        StPdone
    } state_e;

    // ------------------------------------------------------------------------
    // Input synchronisers
    // ------------------------------------------------------------------------
    logic [NPROD-1:0] sreq;
    logic             sack;

    if (SYNC_STAGES == 0) begin : g_nosync
        assign sreq = prod_req;
        assign sack = cons_ack;
    end else begin : g_sync
        logic [SYNC_STAGES-1:0][NPROD-1:0] req_pipe;
        logic [SYNC_STAGES-1:0]            ack_pipe;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                req_pipe <= '0;
                ack_pipe <= '0;
            end else begin
                req_pipe[0] <= prod_req;
                ack_pipe[0] <= cons_ack;
                for (int s = 1; s < int'(SYNC_STAGES); s++) begin
                    req_pipe[s] <= req_pipe[s-1];
                    ack_pipe[s] <= ack_pipe[s-1];
                end
            end
        end

        assign sreq = req_pipe[SYNC_STAGES-1];
        assign sack = ack_pipe[SYNC_STAGES-1];
    end

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_e              state_q, state_d;
    logic                cons_req_q, cons_req_d;
    logic [NPROD-1:0]    prod_ack_q, prod_ack_d;
    logic [DWIDTH-1:0]   cons_dat_q, cons_dat_d;
    logic [IW-1:0]       grant_q, grant_d;
    logic [IW-1:0]       last_q, last_d;

    // ------------------------------------------------------------------------
    // Arbitration: pick the winner among synchronised requests
    // ------------------------------------------------------------------------
    logic [IW-1:0]     sel;
    logic [DWIDTH-1:0] sel_dat;
    logic              any_req;

    always_comb begin
        sel     = '0;
        any_req = |sreq;
        if (PRIO_MODE != 0) begin
            // Walk downwards so the lowest set index is the last to write.
            for (int i = NP - 1; i >= 0; i--) begin
                if (sreq[i]) begin
                    sel = IW'(i);
                end
            end
        end else begin
            // Walk from the farthest offset to the nearest so the first set
            // index after the last grant (with wrap) is the last to write.
            for (int k = NP; k >= 1; k--) begin
                int idx;
                idx = (int'(last_q) + k) % NP;
                if (sreq[idx]) begin
                    sel = IW'(idx);
                end
            end
        end
    end

    always_comb begin
        sel_dat = '0;
        for (int i = 0; i < NP; i++) begin
            if (sel == IW'(i)) begin
                sel_dat = prod_dat[i*DWIDTH +: DWIDTH];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Handshake FSM: next state and registered outputs
    // ------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cons_req_d = cons_req_q;
        prod_ack_d = prod_ack_q;
        cons_dat_d = cons_dat_q;
        grant_d    = grant_q;
        last_d     = last_q;

        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    state_d    = StCreq;
                    cons_req_d = 1'b1;
                    for (int i = 0; i < NP; i++) begin
                        prod_ack_d[i] = (sel == IW'(i));
                    end
                    cons_dat_d = sel_dat;
                    grant_d    = sel;
                    if (PRIO_MODE == 0) begin
                        last_d = sel;
                    end
                end
            end
            StCreq: begin
                if (sack) begin
                    cons_req_d = 1'b0;
                    state_d    = StCack;
                end
            end
            StCack: begin
                if (!sack) begin
                    state_d = StPdone;
                end
            end
            StPdone: begin
                // Producer ack is only released once its request has fallen.
                if (!sreq[grant_q]) begin
                    prod_ack_d = '0;
                    state_d    = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cons_req_q <= 1'b0;
            prod_ack_q <= '0;
            cons_dat_q <= '0;
            grant_q    <= '0;
            // Pointer parked on the top index so index 0 is scanned first.
            last_q     <= IW'(NP - 1);
        end else begin
            state_q    <= state_d;
            cons_req_q <= cons_req_d;
            prod_ack_q <= prod_ack_d;
            cons_dat_q <= cons_dat_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
        end
    end

    assign prod_ack  = prod_ack_q;
    assign cons_req  = cons_req_q;
    assign cons_dat  = cons_dat_q;
    assign grant_idx = grant_q;
    assign busy      = (state_q != StIdle);

endmodule
